// File: rtl/memory_access_if.sv
// rtl/memory_access_if.sv - data memory req/ack bus between the MEM stage and data memory
interface memory_access_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  dmem_req_out;
  logic                  dmem_we_out;
  logic [DATA_WIDTH-1:0] dmem_addr_out;
  logic [DATA_WIDTH-1:0] dmem_wdata_out;
  logic [3:0]            dmem_be_out;
  logic                  dmem_ack_in;
  logic [DATA_WIDTH-1:0] dmem_rdata_in;

  modport master (
    output dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_be_out,
    input  dmem_ack_in, dmem_rdata_in
  );

  modport slave (
    input  dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_be_out,
    output dmem_ack_in, dmem_rdata_in
  );
endinterface

// File: rtl/memory_access.sv
// rtl/memory_access.sv - MEM stage: big-endian lane steering, req/ack data memory access, MEM/WB register (optional MEM_MISALIGN_TRAP_EN)
module memory_access #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [DATA_WIDTH-1:0]     alu_data_in,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic                      mem_rd_in,
  input  logic                      mem_wr_in,
  input  logic [1:0]                mem_size_in,
  input  logic                      mem_signed_in,
  input  logic                      reg_wr_ena_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr_in,
  memory_access_if.master           dmem,
  output logic [DATA_WIDTH-1:0]     wb_data_out,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_addr_out,
  output logic                      wb_reg_wr_ena_out,
  output logic                      stall_out,
  output logic                      bus_error_out,
  output logic                      misalign_out
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TIMEOUT_ON = (TIMEOUT_CYCLES > 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_op, misaligned, start, ack_done, timeout;
  logic [1:0]       lane_off;
  logic [3:0]       be_d;
  logic [31:0]      wdata_d;
  logic             signed_q, rwe_q;
  logic [1:0]       size_q, off_q;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_ext;

  assign mem_op = mem_rd_in | mem_wr_in;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ((mem_size_in == 2'b01) && alu_data_in[0]) ||
                      (mem_size_in[1] && (alu_data_in[1:0] != 2'b00));

  // One-cycle trap pulse for a rejected misaligned access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_out <= 1'b0;
    else        misalign_out <= (state_q == IDLE) && en && mem_op && misaligned;
  end
`else
  assign misaligned   = 1'b0;
  assign misalign_out = 1'b0;
`endif

  // Lane steering: offset masked to the access alignment, big-endian byte enables
  always_comb begin
    lane_off = 2'b00;
    be_d     = 4'b1111;
    wdata_d  = mem_data_in;
    case (mem_size_in)
      2'b00: begin
        lane_off = alu_data_in[1:0];
        be_d     = 4'b1000 >> lane_off;
        wdata_d  = {4{mem_data_in[7:0]}};
      end
      2'b01: begin
        lane_off = {alu_data_in[1], 1'b0};
        be_d     = lane_off[1] ? 4'b0011 : 4'b1100;
        wdata_d  = {2{mem_data_in[15:0]}};
      end
      default: begin
        lane_off = 2'b00;
        be_d     = 4'b1111;
        wdata_d  = mem_data_in;
      end
    endcase
  end

  // Load extraction and sign/zero extension from the latched size/offset
  always_comb begin
    case (off_q)
      2'd0:    byte_sel = dmem.dmem_rdata_in[31:24];
      2'd1:    byte_sel = dmem.dmem_rdata_in[23:16];
      2'd2:    byte_sel = dmem.dmem_rdata_in[15:8];
      default: byte_sel = dmem.dmem_rdata_in[7:0];
    endcase
    half_sel = off_q[1] ? dmem.dmem_rdata_in[15:0] : dmem.dmem_rdata_in[31:16];
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_ext = dmem.dmem_rdata_in;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and transfer events
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    ack_done = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && mem_op && !misaligned) begin
          start   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (dmem.dmem_ack_in) begin
          ack_done = 1'b1;
          state_d  = IDLE;
        end else if (TIMEOUT_ON && (cnt_q == CNT_LAST)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem.dmem_req_out = (state_q == BUSY);
  assign stall_out         = start || ((state_q == BUSY) && !dmem.dmem_ack_in);

  // Timeout counter: counts unacknowledged BUSY cycles, cleared otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                   cnt_q <= '0;
    else if ((state_q == BUSY) && !dmem.dmem_ack_in && !timeout) cnt_q <= cnt_q + 1'b1;
    else                                                          cnt_q <= '0;
  end

  // Bus request latches and the MEM/WB result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem.dmem_we_out    <= 1'b0;
      dmem.dmem_addr_out  <= '0;
      dmem.dmem_wdata_out <= '0;
      dmem.dmem_be_out    <= 4'b0000;
      signed_q            <= 1'b0;
      rwe_q               <= 1'b0;
      size_q              <= 2'b00;
      off_q               <= 2'b00;
      wb_data_out         <= '0;
      wb_reg_addr_out     <= '0;
      wb_reg_wr_ena_out   <= 1'b0;
      bus_error_out       <= 1'b0;
    end else begin
      bus_error_out <= 1'b0;
      if (state_q == IDLE) begin
        if (en && !mem_op) begin
          wb_data_out       <= alu_data_in;
          wb_reg_addr_out   <= reg_addr_in;
          wb_reg_wr_ena_out <= reg_wr_ena_in;
        end else if (en && misaligned) begin
          wb_reg_wr_ena_out <= 1'b0;
        end else if (start) begin
          dmem.dmem_we_out    <= mem_wr_in;
          dmem.dmem_addr_out  <= {alu_data_in[DATA_WIDTH-1:2], 2'b00};
          dmem.dmem_wdata_out <= wdata_d;
          dmem.dmem_be_out    <= be_d;
          signed_q            <= mem_signed_in;
          rwe_q               <= reg_wr_ena_in & ~mem_wr_in;
          size_q              <= mem_size_in;
          off_q               <= lane_off;
          wb_reg_addr_out     <= reg_addr_in;
          wb_reg_wr_ena_out   <= 1'b0;
        end
      end else if (ack_done) begin
        if (!dmem.dmem_we_out) wb_data_out <= load_ext;
        wb_reg_wr_ena_out <= rwe_q;
      end else if (timeout) begin
        wb_reg_wr_ena_out <= 1'b0;
        bus_error_out     <= 1'b1;
      end
    end
  end

endmodule
